dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits LATENCY
// cycles, then presents a registered response until the initiator takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_cnt
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [30:0] DEPTH_L  = 31'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_next;
  logic           r_write;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [3:0]     r_be;
  logic [31:0]    r_rdata;
  logic           r_err;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_accept;
  logic           w_enter_resp;
  logic           w_acc_write;
  logic [31:0]    w_acc_addr;
  logic [31:0]    w_acc_wdata;
  logic [3:0]     w_acc_be;
  logic           w_err;
  logic [AW-1:0]  w_idx;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready depends only on state, and a presented response holds until it is taken.
  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_next = CNT_LOAD;
          if (LATENCY == 1) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accept edge, so use the live inputs then.
  assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_acc_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_err       = (w_acc_addr[1:0] != 2'b00) || ({1'b0, w_acc_addr[31:2]} >= DEPTH_L);
  assign w_idx       = w_acc_addr[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (!w_acc_write && !w_err) ? r_mem[w_idx] : 32'd0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_acc_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (LATENCY 2, 1, 15) on a shared clock.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 1, 15};

  logic        clk;
  logic        rst_n;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic [1:0]  dbg_state [NI];
  logic [3:0]  dbg_cnt   [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0]), .dbg_cnt(dbg_cnt[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1]), .dbg_cnt(dbg_cnt[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .dbg_state(dbg_state[2]), .dbg_cnt(dbg_cnt[2])
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, output int acc_cyc);
    int guard;
    guard        = 0;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    while (!req_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc      = cyc;
    req_valid[k] = 1'b0;
  endtask

  // Counts cycles (1 = first cycle after accept) until rsp_valid is seen.
  task automatic wait_rsp(input int k, output int lat);
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
  endtask

  task automatic xact(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output int acc_cyc);
    issue(k, wr, addr, wdata, be, acc_cyc);
    wait_rsp(k, lat);
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    @(negedge clk);
  endtask

  // Driver / scenario sequence
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc;
    int          prev_acc;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_be[k]    = 4'd0;
      rsp_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(req_ready[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata",     rsp_rdata[0],      32'd0);
    check("rst_err",       32'(rsp_err[0]),   32'd0);
    check("rst_state",     32'(dbg_state[0]), 32'd0);
    check("rst_cnt",       32'(dbg_cnt[0]),   32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // Preload 0x20 with zero for the reset-abort case
    xact(0, 1'b1, 32'h20, 32'h0, 4'hF, rd, er, lat, acc);
    check("pre20_err", 32'(er), 32'd0);

    // Full-word store then load
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, acc);
    check("st10_lat",   32'(lat), 32'd2);
    check("st10_err",   32'(er),  32'd0);
    check("st10_rdata", rd,       32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, acc);
    check("ld10_lat",   32'(lat), 32'd2);
    check("ld10_rdata", rd,       32'hDEADBEEF);
    check("ld10_err",   32'(er),  32'd0);

    // Partial byte-enable store
    xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat, acc);
    check("st_be_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, acc);
    check("ld_be_rdata", rd, 32'hDE22BE44);

    // Zero byte enables: legal no-op
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat, acc);
    check("st_be0_err", 32'(er), 32'd0);

    // Errors: misaligned and out of range
    xact(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat, acc);
    check("mis_err",   32'(er), 32'd1);
    check("mis_rdata", rd,      32'd0);
    xact(0, 1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat, acc);
    check("oor_err",   32'(er), 32'd1);
    check("oor_rdata", rd,      32'd0);
    xact(0, 1'b1, 32'h402, 32'h55555555, 4'hF, rd, er, lat, acc);
    check("oor_st_err", 32'(er), 32'd1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, acc);
    check("ld_after_err", rd, 32'hDE22BE44);

    // Response backpressure with a competing request held on the inputs
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
    wait_rsp(0, lat);
    check("bp_lat", 32'(lat), 32'd2);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hFFFFFFFF;
    req_be[0]    = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", rsp_rdata[0],      32'hDE22BE44);
      check("bp_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_idle",     32'(dbg_state[0]), 32'd0);
    check("bp_valid_lo", 32'(rsp_valid[0]), 32'd0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, acc);
    check("bp_ignored", rd, 32'hDE22BE44);

    // Reset while a store is pending in WAIT
    issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, acc);
    check("ra_in_wait", 32'(dbg_state[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ra_req_ready", 32'(req_ready[0]), 32'd0);
    check("ra_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("ra_rdata",     rsp_rdata[0],      32'd0);
    check("ra_state",     32'(dbg_state[0]), 32'd0);
    check("ra_cnt",       32'(dbg_cnt[0]),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, acc);
    check("ra_ld20", rd, 32'd0);

    // Back-to-back on LATENCY=1 and LATENCY=15 builds: 5 stores then 5 loads
    for (int k = 1; k < NI; k++) begin
      prev_acc = 0;
      for (int i = 0; i < 10; i++) begin
        if (i < 5) begin
          xact(k, 1'b1, 32'h40 + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, rd, er, lat, acc);
          check("b2b_st_rdata", rd, 32'd0);
        end else begin
          xact(k, 1'b0, 32'h40 + 32'(4 * (i - 5)), 32'h0, 4'h0, rd, er, lat, acc);
          check("b2b_ld_rdata", rd, 32'hA500_0000 | 32'(i - 5));
        end
        check("b2b_lat", 32'(lat), 32'(LAT[k]));
        check("b2b_err", 32'(er),  32'd0);
        if (i > 0) check("b2b_period", 32'(acc - prev_acc), 32'(LAT[k] + 1));
        prev_acc = acc;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
